// File: rtl/pu_pkg.sv
// Shared types and widths for the PU sequencer.
// Command layout, FSM states and the fixed PU address widths live here.
package pu_pkg;

    localparam int DATA_W      = 512;
    localparam int WADDR_WIDTH = 7;
    localparam int RADDR_WIDTH = 7;
    localparam int SLOT_W      = 5;
    localparam int BIAS_W      = 3;
    localparam int WROWS_W     = 8;

    localparam logic [WROWS_W-1:0] WROWS_MAX = 8'd128;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_CLEAR,
        S_COMPUTE,
        S_DRAIN,
        S_WB
    } state_e;

    typedef struct packed {
        logic [WROWS_W-1:0]     wrows;
        logic [WADDR_WIDTH-1:0] wbase;
        logic [WADDR_WIDTH-1:0] npass;
        logic [SLOT_W-1:0]      slot;
        logic [RADDR_WIDTH-1:0] raddr;
        logic [BIAS_W-1:0]      bias_addr;
        logic                   add_bias;
        logic                   relu;
    } cmd_t;

    // wmem holds 128 rows, so larger requests are clamped.
    function automatic logic [WROWS_W-1:0] sat_wrows(input logic [WROWS_W-1:0] w);
        return (w > WROWS_MAX) ? WROWS_MAX : w;
    endfunction

endpackage

// File: rtl/pu_seq_cnt.sv
// Loadable up-counter with a terminal-count flag (count == term_i).
// Used for the weight beat index, the pass index and the drain delay.
module pu_seq_cnt #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/pu_seq.sv
// PU command sequencer: weight load, cache clear, MAC passes, drain, rmem writeback.
// Optional build macro PU_SEQ_PERF_EN adds the out_stall_cycles performance counter.
module pu_seq #(
    parameter int DATA_W  = 512,
    parameter int MAC_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_cmd_valid,
    output logic              out_cmd_ready,
    input  logic [7:0]        in_cmd_wrows,
    input  logic [6:0]        in_cmd_wbase,
    input  logic [6:0]        in_cmd_npass,
    input  logic [4:0]        in_cmd_slot,
    input  logic [6:0]        in_cmd_raddr,
    input  logic [2:0]        in_cmd_bias_addr,
    input  logic              in_cmd_add_bias,
    input  logic              in_cmd_relu,
    input  logic              in_w_valid,
    output logic              out_w_ready,
    input  logic [DATA_W-1:0] in_w_data,
    input  logic              in_act_valid,
    output logic              out_act_ready,
    input  logic [DATA_W-1:0] in_act_data,
    output logic              out_mac_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_add_bias,
    output logic              out_relu,
    output logic              out_done,
    output logic              out_cache_clear,
    output logic              out_cache_wr_en,
    output logic [4:0]        out_cache_rd_addr,
    output logic [4:0]        out_cache_wr_addr,
    output logic              out_w_wr_en,
    output logic [6:0]        out_w_wr_addr,
    output logic [DATA_W-1:0] out_w_wr_data,
    output logic [6:0]        out_w_rd_addr,
    output logic [2:0]        out_bias_addr,
    output logic              out_r_wr_en,
    output logic [6:0]        out_r_wr_addr,
    output logic              out_busy,
    output logic              out_cmd_done
`ifdef PU_SEQ_PERF_EN
    ,
    output logic [31:0]       out_stall_cycles
`endif
);

    import pu_pkg::*;

    localparam int DW = $clog2(MAC_LAT + 1);

    state_e state_q, state_d;
    cmd_t   cmd_q, cmd_d;

    logic              w_wr_en_q, w_wr_en_d;
    logic [6:0]        w_wr_addr_q, w_wr_addr_d;
    logic [DATA_W-1:0] w_wr_data_q, w_wr_data_d;
    logic              mac_en_q, mac_en_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [6:0]        w_rd_addr_q, w_rd_addr_d;
    logic [4:0]        cache_rd_addr_q, cache_rd_addr_d;
    logic [4:0]        cache_wr_addr_q, cache_wr_addr_d;
    logic              cache_wr_en_q, cache_wr_en_d;
    logic [2:0]        bias_addr_q, bias_addr_d;
    logic              done_q, done_d;
    logic              add_bias_q, add_bias_d;
    logic              relu_q, relu_d;

    logic cmd_acc, w_acc, act_acc;
    logic [6:0]    k_cnt, p_cnt;
    logic [DW-1:0] drain_cnt_unused;
    logic k_tc, p_tc, d_tc;

    assign out_cmd_ready = (state_q == S_IDLE);
    assign out_w_ready   = (state_q == S_LOAD_W);
    assign out_act_ready = (state_q == S_COMPUTE);

    assign cmd_acc = in_cmd_valid && out_cmd_ready;
    assign w_acc   = in_w_valid && out_w_ready;
    assign act_acc = in_act_valid && out_act_ready;

    pu_seq_cnt #(.W(7)) u_k_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cmd_acc),
        .load_val_i ('0),
        .en_i       (w_acc),
        .term_i     (7'(cmd_q.wrows - 8'd1)),
        .cnt_o      (k_cnt),
        .tc_o       (k_tc)
    );

    pu_seq_cnt #(.W(7)) u_p_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cmd_acc),
        .load_val_i ('0),
        .en_i       (act_acc),
        .term_i     (cmd_q.npass),
        .cnt_o      (p_cnt),
        .tc_o       (p_tc)
    );

    // Restarts on the last pass accept, so DRAIN spans the final MAC cycle plus MAC_LAT.
    pu_seq_cnt #(.W(DW)) u_d_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (act_acc && p_tc),
        .load_val_i ('0),
        .en_i       (state_q == S_DRAIN),
        .term_i     (DW'(MAC_LAT)),
        .cnt_o      (drain_cnt_unused),
        .tc_o       (d_tc)
    );

    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        w_wr_en_d       = 1'b0;
        w_wr_addr_d     = w_wr_addr_q;
        w_wr_data_d     = w_wr_data_q;
        mac_en_d        = 1'b0;
        data_d          = data_q;
        w_rd_addr_d     = w_rd_addr_q;
        cache_rd_addr_d = cache_rd_addr_q;
        cache_wr_addr_d = cache_wr_addr_q;
        cache_wr_en_d   = 1'b0;
        bias_addr_d     = bias_addr_q;
        done_d          = 1'b0;
        add_bias_d      = 1'b0;
        relu_d          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_acc) begin
                    cmd_d.wrows     = sat_wrows(in_cmd_wrows);
                    cmd_d.wbase     = in_cmd_wbase;
                    cmd_d.npass     = in_cmd_npass;
                    cmd_d.slot      = in_cmd_slot;
                    cmd_d.raddr     = in_cmd_raddr;
                    cmd_d.bias_addr = in_cmd_bias_addr;
                    cmd_d.add_bias  = in_cmd_add_bias;
                    cmd_d.relu      = in_cmd_relu;
                    if (in_cmd_wrows == 8'd0) begin
                        state_d         = S_CLEAR;
                        cache_wr_addr_d = in_cmd_slot;
                    end else begin
                        state_d = S_LOAD_W;
                    end
                end
            end
            S_LOAD_W: begin
                if (w_acc) begin
                    w_wr_en_d   = 1'b1;
                    w_wr_addr_d = cmd_q.wbase + k_cnt;
                    w_wr_data_d = in_w_data;
                    if (k_tc) begin
                        state_d         = S_CLEAR;
                        cache_wr_addr_d = cmd_q.slot;
                    end
                end
            end
            S_CLEAR: begin
                state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (act_acc) begin
                    mac_en_d        = 1'b1;
                    data_d          = in_act_data;
                    w_rd_addr_d     = cmd_q.wbase + p_cnt;
                    cache_rd_addr_d = cmd_q.slot;
                    cache_wr_addr_d = cmd_q.slot;
                    cache_wr_en_d   = 1'b1;
                    bias_addr_d     = cmd_q.bias_addr;
                    if (p_tc) begin
                        done_d     = 1'b1;
                        add_bias_d = cmd_q.add_bias;
                        relu_d     = cmd_q.relu;
                        state_d    = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (d_tc) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cmd_q           <= '0;
            w_wr_en_q       <= 1'b0;
            w_wr_addr_q     <= '0;
            w_wr_data_q     <= '0;
            mac_en_q        <= 1'b0;
            data_q          <= '0;
            w_rd_addr_q     <= '0;
            cache_rd_addr_q <= '0;
            cache_wr_addr_q <= '0;
            cache_wr_en_q   <= 1'b0;
            bias_addr_q     <= '0;
            done_q          <= 1'b0;
            add_bias_q      <= 1'b0;
            relu_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cmd_q           <= cmd_d;
            w_wr_en_q       <= w_wr_en_d;
            w_wr_addr_q     <= w_wr_addr_d;
            w_wr_data_q     <= w_wr_data_d;
            mac_en_q        <= mac_en_d;
            data_q          <= data_d;
            w_rd_addr_q     <= w_rd_addr_d;
            cache_rd_addr_q <= cache_rd_addr_d;
            cache_wr_addr_q <= cache_wr_addr_d;
            cache_wr_en_q   <= cache_wr_en_d;
            bias_addr_q     <= bias_addr_d;
            done_q          <= done_d;
            add_bias_q      <= add_bias_d;
            relu_q          <= relu_d;
        end
    end

`ifdef PU_SEQ_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (cmd_acc) begin
            stall_d = '0;
        end else if (((state_q == S_COMPUTE && !in_act_valid) ||
                      (state_q == S_LOAD_W && !in_w_valid)) && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign out_stall_cycles = stall_q;
`endif

    // Cache clear is active-low and only asserted during the single CLEAR cycle.
    assign out_cache_clear   = (state_q != S_CLEAR);
    assign out_r_wr_en       = (state_q == S_WB);
    assign out_r_wr_addr     = out_r_wr_en ? cmd_q.raddr : '0;
    assign out_cmd_done      = out_r_wr_en;
    assign out_busy          = (state_q != S_IDLE);

    assign out_w_wr_en       = w_wr_en_q;
    assign out_w_wr_addr     = w_wr_addr_q;
    assign out_w_wr_data     = w_wr_data_q;
    assign out_mac_en        = mac_en_q;
    assign out_data          = data_q;
    assign out_w_rd_addr     = w_rd_addr_q;
    assign out_cache_rd_addr = cache_rd_addr_q;
    assign out_cache_wr_addr = cache_wr_addr_q;
    assign out_cache_wr_en   = cache_wr_en_q;
    assign out_bias_addr     = bias_addr_q;
    assign out_done          = done_q;
    assign out_add_bias      = add_bias_q;
    assign out_relu          = relu_q;

endmodule

// File: tb/tb_pu_seq.sv
// Scoreboard bench for pu_seq: stimulus tasks queue expected PU events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_pu_seq;

    localparam int DW = 512;
    localparam int ML = 2;

    logic          clk, rst;
    logic          in_cmd_valid, out_cmd_ready;
    logic [7:0]    in_cmd_wrows;
    logic [6:0]    in_cmd_wbase, in_cmd_npass, in_cmd_raddr;
    logic [4:0]    in_cmd_slot;
    logic [2:0]    in_cmd_bias_addr;
    logic          in_cmd_add_bias, in_cmd_relu;
    logic          in_w_valid, out_w_ready;
    logic [DW-1:0] in_w_data;
    logic          in_act_valid, out_act_ready;
    logic [DW-1:0] in_act_data;
    logic          out_mac_en, out_add_bias, out_relu, out_done;
    logic [DW-1:0] out_data, out_w_wr_data;
    logic          out_cache_clear, out_cache_wr_en;
    logic [4:0]    out_cache_rd_addr, out_cache_wr_addr;
    logic          out_w_wr_en;
    logic [6:0]    out_w_wr_addr, out_w_rd_addr, out_r_wr_addr;
    logic [2:0]    out_bias_addr;
    logic          out_r_wr_en, out_busy, out_cmd_done;
`ifdef PU_SEQ_PERF_EN
    logic [31:0]   out_stall_cycles;
`endif

    pu_seq #(.DATA_W(DW), .MAC_LAT(ML)) dut (
        .clk(clk), .rst(rst),
        .in_cmd_valid(in_cmd_valid), .out_cmd_ready(out_cmd_ready),
        .in_cmd_wrows(in_cmd_wrows), .in_cmd_wbase(in_cmd_wbase),
        .in_cmd_npass(in_cmd_npass), .in_cmd_slot(in_cmd_slot),
        .in_cmd_raddr(in_cmd_raddr), .in_cmd_bias_addr(in_cmd_bias_addr),
        .in_cmd_add_bias(in_cmd_add_bias), .in_cmd_relu(in_cmd_relu),
        .in_w_valid(in_w_valid), .out_w_ready(out_w_ready), .in_w_data(in_w_data),
        .in_act_valid(in_act_valid), .out_act_ready(out_act_ready), .in_act_data(in_act_data),
        .out_mac_en(out_mac_en), .out_data(out_data), .out_add_bias(out_add_bias),
        .out_relu(out_relu), .out_done(out_done), .out_cache_clear(out_cache_clear),
        .out_cache_wr_en(out_cache_wr_en), .out_cache_rd_addr(out_cache_rd_addr),
        .out_cache_wr_addr(out_cache_wr_addr), .out_w_wr_en(out_w_wr_en),
        .out_w_wr_addr(out_w_wr_addr), .out_w_wr_data(out_w_wr_data),
        .out_w_rd_addr(out_w_rd_addr), .out_bias_addr(out_bias_addr),
        .out_r_wr_en(out_r_wr_en), .out_r_wr_addr(out_r_wr_addr),
        .out_busy(out_busy), .out_cmd_done(out_cmd_done)
`ifdef PU_SEQ_PERF_EN
        , .out_stall_cycles(out_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    int wb_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [6:0]    addr;
        logic [DW-1:0] data;
    } w_exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [6:0]    rd;
        logic [4:0]    slot;
        logic [2:0]    bias;
        logic          done;
        logic          ab;
        logic          rl;
    } mac_exp_t;

    w_exp_t     wq[$];
    mac_exp_t   macq[$];
    logic [4:0] clrq[$];
    logic [6:0] wbq[$];

    task automatic chk(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic fail(input string nm);
        nchk++;
        nerr++;
        $display("FAIL %s", nm);
    endtask

    // Monitor: every DUT-presented event must match the head of its queue.
    w_exp_t   we;
    mac_exp_t me;
    always @(negedge clk) begin
        if (out_w_wr_en === 1'b1) begin
            if (wq.size() == 0) fail("w_wr_unexpected");
            else begin
                we = wq.pop_front();
                chk("w_wr_addr", out_w_wr_addr, we.addr);
                chk("w_wr_data", out_w_wr_data, we.data);
            end
        end
        if (out_cache_clear === 1'b0) begin
            if (clrq.size() == 0) fail("clear_unexpected");
            else chk("clear_slot", out_cache_wr_addr, clrq.pop_front());
        end
        if (out_mac_en === 1'b1) begin
            if (macq.size() == 0) fail("mac_unexpected");
            else begin
                me = macq.pop_front();
                chk("mac_data", out_data, me.data);
                chk("mac_w_rd_addr", out_w_rd_addr, me.rd);
                chk("mac_cache_addrs", {out_cache_wr_en, out_cache_rd_addr, out_cache_wr_addr},
                    {1'b1, me.slot, me.slot});
                chk("mac_bias_addr", out_bias_addr, me.bias);
                chk("mac_done_bias_relu", {out_done, out_add_bias, out_relu}, {me.done, me.ab, me.rl});
                if (out_done === 1'b1) last_done_cyc = cyc;
            end
        end else if (out_cache_wr_en === 1'b1) begin
            fail("cache_wr_without_mac");
        end
        if (out_r_wr_en === 1'b1) begin
            if (wbq.size() == 0) fail("r_wr_unexpected");
            else begin
                chk("wb_raddr", out_r_wr_addr, wbq.pop_front());
                chk("wb_cmd_done", out_cmd_done, 1'b1);
                chk("wb_latency", cyc - last_done_cyc, ML + 1);
                wb_cyc = cyc;
                $display("wb: raddr=%0d cycle=%0d", out_r_wr_addr, cyc);
            end
        end else if (out_cmd_done === 1'b1) begin
            fail("cmd_done_without_wb");
        end
    end

    task automatic set_cmd(input logic [7:0] wr, input logic [6:0] wb, input logic [6:0] np,
                           input logic [4:0] sl, input logic [6:0] ra, input logic [2:0] bi,
                           input logic ab, input logic rl);
        in_cmd_wrows = wr; in_cmd_wbase = wb; in_cmd_npass = np; in_cmd_slot = sl;
        in_cmd_raddr = ra; in_cmd_bias_addr = bi; in_cmd_add_bias = ab; in_cmd_relu = rl;
        in_cmd_valid = 1'b1;
        clrq.push_back(sl);
        wbq.push_back(ra);
    endtask

    task automatic wait_cmd_ready();
        int n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (out_cmd_ready) break;
            n++;
        end
        if (!out_cmd_ready) fail("cmd_ready_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] wr, input logic [6:0] wb, input logic [6:0] np,
                            input logic [4:0] sl, input logic [6:0] ra, input logic [2:0] bi,
                            input logic ab, input logic rl);
        set_cmd(wr, wb, np, sl, ra, bi, ab, rl);
        wait_cmd_ready();
        in_cmd_valid = 1'b0;
    endtask

    task automatic send_w(input logic [6:0] exp_addr, input logic [DW-1:0] d);
        int n = 0;
        wq.push_back('{addr: exp_addr, data: d});
        in_w_valid = 1'b1;
        in_w_data  = d;
        while (n < 50) begin
            @(negedge clk);
            if (out_w_ready) break;
            n++;
        end
        if (!out_w_ready) fail("w_ready_timeout");
        @(posedge clk);
        #1;
        in_w_valid = 1'b0;
    endtask

    task automatic send_act(input logic [DW-1:0] d, input logic [6:0] rd, input logic [4:0] sl,
                            input logic [2:0] bi, input logic dn, input logic ab, input logic rl);
        int n = 0;
        macq.push_back('{data: d, rd: rd, slot: sl, bias: bi, done: dn, ab: ab, rl: rl});
        in_act_valid = 1'b1;
        in_act_data  = d;
        while (n < 50) begin
            @(negedge clk);
            if (out_act_ready) break;
            n++;
        end
        if (!out_act_ready) fail("act_ready_timeout");
        @(posedge clk);
        #1;
        in_act_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (!out_busy) break;
            n++;
        end
        if (out_busy) fail("idle_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_enables"}, {out_w_wr_en, out_mac_en, out_cache_wr_en, out_r_wr_en, out_cmd_done,
             out_done, out_add_bias, out_relu, out_w_ready, out_act_ready, out_busy}, '0);
        chk({tag, "_ready_clear"}, {out_cmd_ready, out_cache_clear}, 2'b11);
        chk({tag, "_addrs"}, {out_w_wr_addr, out_w_rd_addr, out_r_wr_addr, out_cache_rd_addr,
             out_cache_wr_addr, out_bias_addr}, '0);
        chk({tag, "_data"}, out_data, '0);
        chk({tag, "_w_wr_data"}, out_w_wr_data, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_cmd_valid = 1'b0; in_w_valid = 1'b0; in_act_valid = 1'b0;
        in_w_data = '0; in_act_data = '0;
        in_cmd_wrows = '0; in_cmd_wbase = '0; in_cmd_npass = '0; in_cmd_slot = '0;
        in_cmd_raddr = '0; in_cmd_bias_addr = '0; in_cmd_add_bias = 1'b0; in_cmd_relu = 1'b0;
        idle(2);
        check_reset("reset");
        rst = 1'b0;

        // Load path: two weight rows, single pass.
        send_cmd(8'd2, 7'd0, 7'd0, 5'd3, 7'd9, 3'd1, 1'b0, 1'b0);
        chk("busy_after_accept", out_busy, 1'b1);
        send_w(7'd0, 512'd1);
        send_w(7'd1, 512'd2);
        send_act(512'd1, 7'd0, 5'd3, 3'd1, 1'b1, 1'b0, 1'b0);
        wait_idle();

        // Multi-pass with bias and ReLU on the last pass only.
        send_cmd(8'd0, 7'd5, 7'd3, 5'd7, 7'd20, 3'd5, 1'b1, 1'b1);
        for (int p = 0; p < 4; p++)
            send_act(512'h10 + 512'(p), 7'(5 + p), 5'd7, 3'd5, p == 3, p == 3, p == 3);
        wait_idle();

        // Backpressure: act valid pattern 1,0,0,1.
        send_cmd(8'd0, 7'd10, 7'd1, 5'd2, 7'd33, 3'd2, 1'b0, 1'b1);
        send_act(512'hAA, 7'd10, 5'd2, 3'd2, 1'b0, 1'b0, 1'b0);
        idle(2);
        send_act(512'hBB, 7'd11, 5'd2, 3'd2, 1'b1, 1'b0, 1'b1);
        wait_idle();
`ifdef PU_SEQ_PERF_EN
        chk("stall_cycles", out_stall_cycles, 32'd2);
`endif

        // Address wrap on wmem writes.
        send_cmd(8'd4, 7'd126, 7'd0, 5'd4, 7'd127, 3'd3, 1'b1, 1'b0);
        send_w(7'd126, 512'h11);
        send_w(7'd127, 512'h22);
        send_w(7'd0,   512'h33);
        send_w(7'd1,   512'h44);
        send_act(512'h55, 7'd126, 5'd4, 3'd3, 1'b1, 1'b1, 1'b0);
        wait_idle();

        // wrows above 128 saturates to 128 beats.
        send_cmd(8'd200, 7'd0, 7'd0, 5'd31, 7'd1, 3'd7, 1'b0, 1'b0);
        for (int i = 0; i < 128; i++)
            send_w(7'(i), 512'h1000 + 512'(i));
        send_act(512'h77, 7'd0, 5'd31, 3'd7, 1'b1, 1'b0, 1'b0);
        wait_idle();

        // Reset in the middle of COMPUTE after two of four passes.
        send_cmd(8'd0, 7'd40, 7'd3, 5'd9, 7'd50, 3'd4, 1'b1, 1'b1);
        send_act(512'h61, 7'd40, 5'd9, 3'd4, 1'b0, 1'b0, 1'b0);
        send_act(512'h62, 7'd41, 5'd9, 3'd4, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idle(1);
        check_reset("midreset");
        rst = 1'b0;
        wbq.delete();
        chk("midreset_mac_queue", macq.size(), 0);
        idle(10);

        // Command held valid through a busy command: second one accepted exactly once.
        set_cmd(8'd0, 7'd3, 7'd0, 5'd1, 7'd30, 3'd0, 1'b0, 1'b0);
        wait_cmd_ready();
        set_cmd(8'd0, 7'd8, 7'd0, 5'd2, 7'd31, 3'd6, 1'b1, 1'b0);
        send_act(512'h91, 7'd3, 5'd1, 3'd0, 1'b1, 1'b0, 1'b0);
        begin
            int n = 0;
            while (n < 50) begin
                @(negedge clk);
                if (out_cmd_ready) break;
                n++;
            end
            if (!out_cmd_ready) fail("busy_ready_timeout");
            else chk("busy_accept_cycle", cyc, wb_cyc + 1);
        end
        @(posedge clk);
        #1;
        in_cmd_valid = 1'b0;
        send_act(512'h92, 7'd8, 5'd2, 3'd6, 1'b1, 1'b1, 1'b0);
        wait_idle();
        idle(8);

        chk("w_queue_empty", wq.size(), 0);
        chk("mac_queue_empty", macq.size(), 0);
        chk("clear_queue_empty", clrq.size(), 0);
        chk("wb_queue_empty", wbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/pu_seq.md
Name: pu_seq

Overview:
- Command-driven sequencer that acts as the initiator of the PU control interface.
- Per layer command it loads weight rows into PU wmem, streams activation beats through the MAC cluster, and accumulates partial sums in the cache slot.
- On the last pass it applies bias/ReLU, then commits the result to rmem.
- Sits between the top-level layer scheduler and one PU instance.

Parameters:
- DATA_W, 512, width of weight/activation beat (NUM_MAC4*4*DATA_WIDTH)
- WADDR_WIDTH, 7, wmem address width
- RADDR_WIDTH, 7, rmem address width
- MAC_LAT, 2, cycles from last MAC-enabled beat to valid PU total sum (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_cmd_valid  in  1  command valid
- out_cmd_ready  out  1  high only in IDLE
- in_cmd_wrows  in  8  weight rows to load, 0..128; 0 = skip load
- in_cmd_wbase  in  7  first wmem row
- in_cmd_npass  in  7  passes minus 1
- in_cmd_slot  in  5  cache slot
- in_cmd_raddr  in  7  rmem destination
- in_cmd_bias_addr  in  3  bias index
- in_cmd_add_bias  in  1  add bias on last pass
- in_cmd_relu  in  1  ReLU on last pass
- in_w_valid  in  1  weight beat valid
- out_w_ready  out  1  weight beat ready
- in_w_data  in  DATA_W  weight beat
- in_act_valid  in  1  activation beat valid
- out_act_ready  out  1  activation beat ready
- in_act_data  in  DATA_W  activation beat
- out_mac_en, out_data[DATA_W], out_add_bias, out_relu, out_done, out_cache_clear, out_cache_wr_en, out_cache_rd_addr[5], out_cache_wr_addr[5]  out  PU MAC controls
- out_w_wr_en, out_w_wr_addr[7], out_w_wr_data[DATA_W], out_w_rd_addr[7], out_bias_addr[3]  out  PU wmem controls
- out_r_wr_en, out_r_wr_addr[7]  out  PU rmem write
- out_busy  out  1  not IDLE
- out_cmd_done  out  1  one-cycle pulse when the command retires

Behaviour:
- Reset (also mid-command): FSM enters IDLE; all counters are cleared.
  - Output reset values: all enables 0, all addresses/data 0, out_cache_clear=1 (clear is active-low), out_cmd_ready=1.
  - Any partially accepted command is dropped.
- Handshakes:
  - A transfer occurs when valid && ready in the same cycle.
  - Ready does not depend combinationally on valid.
  - Command fields are registered on acceptance.
- FSM: IDLE -> LOAD_W -> CLEAR -> COMPUTE -> DRAIN -> WB -> IDLE.
- IDLE:
  - out_cmd_ready=1.
  - On accept, go to LOAD_W, or go to CLEAR if wrows=0.
- LOAD_W:
  - out_w_ready=1.
  - Each accepted beat drives out_w_wr_en=1, out_w_wr_data=in_w_data, out_w_wr_addr=(wbase+k) mod 128, where k counts accepted beats.
  - Outputs are registered: the write appears the cycle after acceptance.
  - After wrows beats, go to CLEAR.
  - wrows>128 is saturated to 128.
- CLEAR:
  - One cycle with out_cache_clear=0 and out_cache_wr_addr=slot.
  - Then go to COMPUTE.
- COMPUTE:
  - out_act_ready=1.
  - Pass p (0..npass) is consumed by one accepted act beat.
  - On acceptance the following cycle drives:
    - out_mac_en=1, out_data=in_act_data;
    - out_w_rd_addr=(wbase+p) mod 128;
    - out_cache_rd_addr=out_cache_wr_addr=slot, out_cache_wr_en=1;
    - out_bias_addr=bias_addr.
  - On the last pass p=npass, additionally out_done=1, out_add_bias=add_bias, out_relu=relu.
  - With no accepted beat, out_mac_en=0 and out_cache_wr_en=0 (stall; no bubble penalty).
  - After the last pass, go to DRAIN.
- DRAIN:
  - Waits exactly MAC_LAT cycles counted from the last MAC cycle, then goes to WB.
- WB:
  - One cycle with out_r_wr_en=1, out_r_wr_addr=raddr, and out_cmd_done=1.
  - Then go to IDLE; the next command is accepted one cycle later, at the earliest.
- Weight and act beats offered outside their states are not accepted (ready=0).
- npass=0 means a single pass; that pass carries done, bias and ReLU.
- Address arithmetic is modulo 2^7 and wraps silently.

Optional Feature:
- Macro PU_SEQ_PERF_EN.
- Defined:
  - Adds output out_stall_cycles[31:0], a count of COMPUTE cycles with in_act_valid=0 plus LOAD_W cycles with in_w_valid=0.
  - Counter is cleared on rst and on command accept, and saturates at 2^32-1.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pu_pkg holds:
  - FSM state enum;
  - widths DATA_W, WADDR_WIDTH, RADDR_WIDTH, cache-slot width 5, bias-index width 3;
  - command struct (wrows, wbase, npass, slot, raddr, bias_addr, add_bias, relu).
- One natural sub-module, pu_seq_cnt: a loadable up-counter with terminal-count flag, instanced for beat index k, pass index p and drain delay.

Test Plan:
- Load path: cmd wrows=2, wbase=0, npass=0; w beats 1 then 2; act beat 1 -> out_w_wr_en at addr 0 then 1.
  - Then out_cache_clear=0 for one cycle.
  - Then one MAC cycle with done=1 and w_rd_addr=0.
  - Then out_r_wr_en MAC_LAT+1 cycles later, with cmd_done.
- Multi-pass: wrows=0, wbase=5, npass=3, add_bias=1, relu=1 -> four MAC cycles with w_rd_addr 5,6,7,8; done/add_bias/relu high only on the 4th.
- Backpressure: in_act_valid toggles 1,0,0,1 -> mac_en follows with one-cycle delay, no duplicate or skipped pass, stall counter=2 when PU_SEQ_PERF_EN is defined.
- Wrap: wrows=4, wbase=126 -> wmem writes at 126,127,0,1.
- Reset mid-COMPUTE after 2 of 4 passes -> next cycle all outputs at reset values, out_cmd_ready=1, no r_wr_en ever issued.
- Command during busy: hold in_cmd_valid through a command -> out_cmd_ready=0 until the cycle after WB; second command is accepted exactly once.
